fetch_cache: RTL and testbench
==============================

Name: fetch_cache

Overview:
- Direct-mapped, read-only, single-word-block cache between a CPU datapath fetch port and the shared memory controller.
- Datapath side uses the datapath_cache_if fetch signals; memory side uses the cache_control_if instruction channel for one CPU.
- Hits return in the same cycle. Misses stall the datapath, fetch one word from the controller, and fill the frame.

Parameters:
- CPUID, 0, index of this CPU's slot on the cache_control_if arrays. Used only for naming and connection; no logic depends on it.
- SETS, 16, number of frames. Must be a power of two.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- imemREN  input  1  datapath fetch request
- imemaddr  input  32  datapath fetch byte address
- ihit  output  1  request satisfied this cycle
- imemload  output  32  fetched word
- iwait  input  1  memory controller busy; word not yet valid
- iload  input  32  word returned by the memory controller
- iREN  output  1  read request to the memory controller
- iaddr  output  32  read address to the memory controller
- hit_count  output  32  number of completed hits
- miss_count  output  32  number of misses serviced

Behaviour:
- Address split (SETS=16):
  - offset = imemaddr[1:0], ignored.
  - index = imemaddr[5:2].
  - tag = imemaddr[31:6].
  - Generally, index width = log2(SETS) and the tag takes the remaining upper bits.
- Frame contents: valid bit, tag, 32-bit data.
- Reset (nRST=0, asynchronous):
  - All valid bits, tags, data and both counters clear to 0.
  - FSM goes to IDLE.
  - Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
- hit = valid[index] && tag[index]==tag(imemaddr). This is combinational.
- FSM states IDLE and FILL.
- IDLE:
  - If imemREN && hit: ihit=1, imemload=data[index] in the same cycle, hit_count increments on the clock edge.
  - If imemREN && !hit: go to FILL on the next edge. ihit=0.
  - If !imemREN: ihit=0, iREN=0, imemload = data[index] (don't-care for the datapath).
- FILL:
  - iREN=1 and iaddr = {imemaddr[31:2],2'b00}, held every cycle.
  - While iwait=1: no state change.
  - When iwait=0, on that edge: data[index]=iload, tag[index]=tag, valid[index]=1, miss_count increments, return to IDLE.
  - The next cycle hits, so miss latency = controller latency + 1 cycle.
  - ihit stays 0 throughout FILL.
- Outside FILL: iREN=0 and iaddr=0.
- Request changes during FILL:
  - If imemREN drops during FILL: abort, return to IDLE, no fill, no count.
  - If imemaddr changes during FILL: iaddr follows it. The returned word fills the frame for the current address.
- Conflict: a fill overwrites the resident frame unconditionally. There is no write-back; the cache is read-only.
- Reset asserted mid-FILL: immediate return to IDLE with everything cleared; the pending controller response is ignored.
- Counters wrap modulo 2^32.

Test Plan:
- Compulsory miss: reset, then imemREN=1, imemaddr=0x04. Required: ihit=0, iREN=1, iaddr=0x04 until iwait=0. The following cycle: ihit=1, imemload = RAM[0x04], miss_count=1.
- Re-request the same data: imemaddr=0x04 held 3 cycles after the fill. Required: ihit=1 every cycle, iREN=0, hit_count=3.
- Neighbouring address: imemaddr=0x00 after 0x04 is loaded. Required: miss (different index), fill, then both 0x00 and 0x04 hit.
- Same index, different tag: load 0x04, then request 0x44. Required: miss, frame 1 replaced. Re-requesting 0x04 then misses again.
- Fill cache: addresses 0x00..0x24 step 4 (10 words) each miss once, then each hits on a second pass. Required: miss_count=10, hit_count=10, imemload matches RAM.
- Reset mid-fill: assert nRST=0 while iwait=1. Required: iREN=0 and ihit=0 immediately. After release, the prior address misses again.

Source files
------------

// File: rtl/fetch_cache.sv
// fetch_cache: direct-mapped, read-only, one-word-per-frame instruction cache with a single-word miss fill.
module fetch_cache #(
    parameter int CPUID = 0,
    parameter int SETS  = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [SETS-1:0] valid_q;
    logic [TW-1:0] tag_q [SETS];
    logic [31:0]   data_q [SETS];
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit;
    logic          fill;
    logic [33:0]   unused_bits;

    // The byte offset and CPU slot number carry no logic.
    assign unused_bits = {32'(CPUID), imemaddr[1:0]};

    assign idx      = imemaddr[IW+1:2];
    assign tag      = imemaddr[31:IW+2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign fill     = (state_q == FILL) && imemREN && !iwait;
    assign ihit     = (state_q == IDLE) && imemREN && hit;
    assign imemload = data_q[idx];
    assign iREN     = (state_q == FILL);
    assign iaddr    = iREN ? {imemaddr[31:2], 2'b00} : 32'd0;

    // Next state: a missing request enters FILL; FILL leaves on word arrival or when the request drops.
    always_comb begin
        state_d = (state_q == IDLE) ? ((imemREN && !hit) ? FILL : IDLE)
                                    : ((!imemREN || !iwait) ? IDLE : FILL);
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Frame store: the returned word overwrites whatever frame the current address indexes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
            tag_q[idx]   <= tag;
            data_q[idx]  <= iload;
        end
    end

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) hit_count  <= hit_count + 32'd1;
            if (fill) miss_count <= miss_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_fetch_cache.sv
// tb_fetch_cache: randomized and directed checks of fetch_cache against a cache-contents reference model.
module tb_fetch_cache;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, hit_count, miss_count;

    int n_checks = 0;
    int n_fail = 0;

    bit          m_valid [16];
    logic [25:0] m_tag [16];
    bit          pend;
    bit          served;
    logic [31:0] m_hits, m_misses;

    fetch_cache #(.CPUID(0), .SETS(16)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iwait(iwait), .iload(iload),
        .iREN(iREN), .iaddr(iaddr), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ram(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_mem();
        iload = iwait ? $urandom : ram(imemaddr);
    endtask

    task automatic cyc();
        logic [3:0] i;
        bit exp_hit;
        @(negedge CLK);
        i = imemaddr[5:2];
        exp_hit = !pend && imemREN && m_valid[i] && (m_tag[i] == imemaddr[31:6]);
        check("ihit", 32'(ihit), 32'(exp_hit));
        check("iREN", 32'(iREN), 32'(pend));
        check("iaddr", iaddr, pend ? {imemaddr[31:2], 2'b00} : 32'd0);
        if (exp_hit) check("imemload", imemload, ram(imemaddr));
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        @(posedge CLK);
        served = 1'b0;
        if (!pend) begin
            if (exp_hit) begin
                m_hits++;
                served = 1'b1;
            end else if (imemREN) pend = 1'b1;
        end else if (!imemREN) pend = 1'b0;
        else if (!iwait) begin
            m_valid[i] = 1'b1;
            m_tag[i] = imemaddr[31:6];
            m_misses++;
            pend = 1'b0;
            served = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        #2 nRST = 1'b0;
        #1;
        check("rst_iREN", 32'(iREN), 32'd0);
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        for (int k = 0; k < 16; k++) begin
            m_valid[k] = 1'b0;
            m_tag[k] = '0;
        end
        pend = 1'b0;
        m_hits = '0;
        m_misses = '0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a, input int lat);
        int k = 0;
        served = 1'b0;
        imemREN = 1'b1;
        imemaddr = a;
        while (!served && k < 40) begin
            iwait = (k < lat);
            drive_mem();
            cyc();
            k++;
        end
        check("fetch_done", 32'(served), 32'd1);
    endtask

    initial begin
        do_reset();
        // compulsory miss, then the same word hits three times
        fetch(32'h04, 3);
        check("compulsory_misses", miss_count, 32'd1);
        repeat (3) fetch(32'h04, 0);
        check("rehit_hits", hit_count, 32'd3);
        // neighbouring index, then both resident
        fetch(32'h00, 2);
        fetch(32'h00, 0);
        fetch(32'h04, 0);
        check("neighbour_hits", hit_count, 32'd5);
        check("neighbour_misses", miss_count, 32'd2);
        // same index, different tag evicts
        fetch(32'h44, 1);
        fetch(32'h04, 1);
        check("conflict_misses", miss_count, 32'd4);
        // fill ten frames then hit them all
        do_reset();
        for (int a = 0; a <= 32'h24; a += 4) fetch(32'(a), 1 + a % 3);
        for (int a = 0; a <= 32'h24; a += 4) fetch(32'(a), 2);
        check("fill_misses", miss_count, 32'd10);
        check("fill_hits", hit_count, 32'd10);
        // request dropped mid-fill
        imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1; drive_mem();
        repeat (2) cyc();
        imemREN = 1'b0; iwait = 1'b0; drive_mem();
        cyc();
        check("abort_misses", miss_count, 32'd10);
        fetch(32'h80, 1);
        check("abort_refill", miss_count, 32'd11);
        // reset in the middle of a fill
        imemREN = 1'b1; imemaddr = 32'h08; iwait = 1'b1; drive_mem();
        repeat (2) cyc();
        do_reset();
        fetch(32'h08, 2);
        check("rst_fill_misses", miss_count, 32'd1);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 3)
                imemaddr = {($urandom_range(0, 1) != 0) ? 24'hFFFFFF : 24'h0,
                            2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
            imemREN = ($urandom_range(0, 7) != 0);
            iwait = ($urandom_range(0, 2) != 0);
            drive_mem();
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
